// File: rtl/execute_node_mix_banked_ram_if.sv
// Access bus for execute_node_mix_banked_ram: read/write port 0, read-only port 1,
// and the init_done status that gates both ports.
interface execute_node_mix_banked_ram_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5
);
    logic                    init_done;
    logic [AddressWidth-1:0] address0;
    logic                    ce0;
    logic                    we0;
    logic [DataWidth-1:0]    d0;
    logic [DataWidth-1:0]    q0;
    logic                    q0_vld;
    logic [AddressWidth-1:0] address1;
    logic                    ce1;
    logic [DataWidth-1:0]    q1;
    logic                    q1_vld;
    logic                    coll1;

    modport master (
        input  init_done, q0, q0_vld, q1, q1_vld, coll1,
        output address0, ce0, we0, d0, address1, ce1
    );

    modport slave (
        output init_done, q0, q0_vld, q1, q1_vld, coll1,
        input  address0, ce0, we0, d0, address1, ce1
    );
endinterface

// File: rtl/execute_node_mix_banked_ram.sv
// Banked node-mix RAM: self-clearing after reset, read-first port 0, read-only port 1.
// Build option NODE_MIX_COLLISION_FWD_EN forwards d0 to q1 on a same-address collision.
module execute_node_mix_banked_ram #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5,
    parameter int AddressRange = 32,
    parameter int NumBanks     = 2,
    parameter int OutReg       = 1
) (
    input logic                   clk,
    input logic                   reset,
    execute_node_mix_banked_ram_if.slave bus
);
    localparam int Depth    = AddressRange / NumBanks;
    localparam int PtrBits  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int BankBits = (NumBanks > 1) ? $clog2(NumBanks) : 1;

`ifdef NODE_MIX_COLLISION_FWD_EN
    localparam bit CollFwd = 1'b1;
`else
    localparam bit CollFwd = 1'b0;
`endif

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]         state;
    logic [PtrBits-1:0] ptr;
    logic               init_done_r;

    logic [DataWidth-1:0] mem [NumBanks][Depth];

    logic [BankBits-1:0]  bank0, bank1;
    logic [PtrBits-1:0]   row0, row1;
    logic                 inr0, inr1;
    logic                 acc0, acc1, wr0, coll_now;
    logic [DataWidth-1:0] rd0, rd1;

    logic                 s1_v0, s1_v1, s1_c1;
    logic [DataWidth-1:0] s1_q0, s1_q1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            ptr         <= '0;
            init_done_r <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == PtrBits'(Depth - 1)) begin
                        state       <= ST_READY;
                        init_done_r <= 1'b1;
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end

    // Word address splits as low bits = bank, high bits = row within bank.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        inr0     = 32'(bus.address0) < 32'(AddressRange);
        inr1     = 32'(bus.address1) < 32'(AddressRange);
        bank0    = BankBits'(32'(bus.address0) % 32'(NumBanks));
        bank1    = BankBits'(32'(bus.address1) % 32'(NumBanks));
        row0     = PtrBits'(32'(bus.address0) / 32'(NumBanks));
        row1     = PtrBits'(32'(bus.address1) / 32'(NumBanks));
        acc0     = (state == ST_READY) && !reset && bus.ce0;
        acc1     = (state == ST_READY) && !reset && bus.ce1;
        wr0      = acc0 && bus.we0 && inr0;
        coll_now = acc0 && bus.we0 && acc1 && (bus.address0 == bus.address1);
        rd0      = '0;
        rd1      = '0;
        if (inr0) rd0 = mem[bank0][row0];
        if (inr1) rd1 = (CollFwd && coll_now) ? bus.d0 : mem[bank1][row1];
    end

    // NOTE: the array has no reset branch; the INIT sweep clears it one row per cycle.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            for (int b = 0; b < NumBanks; b++) mem[b][ptr] <= '0;
        end else if (wr0) begin
            mem[bank0][row0] <= bus.d0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v0 <= 1'b0;
            s1_v1 <= 1'b0;
            s1_c1 <= 1'b0;
            s1_q0 <= '0;
            s1_q1 <= '0;
        end else begin
            s1_v0 <= acc0;
            s1_v1 <= acc1;
            s1_c1 <= coll_now;
            if (acc0) s1_q0 <= rd0;
            if (acc1) s1_q1 <= rd1;
        end
    end

    generate
        if (OutReg != 0) begin : g_out_reg
            logic                 v0_r, v1_r, c1_r;
            logic [DataWidth-1:0] q0_r, q1_r;

            // Data only moves on a completing read so q holds between pulses.
            always_ff @(posedge clk) begin
                if (reset) begin
                    v0_r <= 1'b0;
                    v1_r <= 1'b0;
                    c1_r <= 1'b0;
                    q0_r <= '0;
                    q1_r <= '0;
                end else begin
                    v0_r <= s1_v0;
                    v1_r <= s1_v1;
                    c1_r <= s1_c1;
                    if (s1_v0) q0_r <= s1_q0;
                    if (s1_v1) q1_r <= s1_q1;
                end
            end

            assign bus.q0     = q0_r;
            assign bus.q0_vld = v0_r;
            assign bus.q1     = q1_r;
            assign bus.q1_vld = v1_r;
            assign bus.coll1  = c1_r;
        end else begin : g_no_out_reg
            assign bus.q0     = s1_q0;
            assign bus.q0_vld = s1_v0;
            assign bus.q1     = s1_q1;
            assign bus.q1_vld = s1_v1;
            assign bus.coll1  = s1_c1;
        end
    endgenerate

    assign bus.init_done = init_done_r;
endmodule
